sprite_blitter: RTL and testbench
=================================

// Module: sprite_blitter
// PURPOSE
//  Writer-side counterpart to the sprite/background frame ROMs. Copies a rectangular sprite of palette
//  indices from a sync-read sprite ROM into the frame-buffer RAM, one pixel per clock. Skips
//  transparent pixels and clips at screen edges. Sits between game logic (issues blit jobs) and the
//  frame-buffer write port; the VGA path reads the frame buffer elsewhere.
// PARAMETERS
//  SCREEN_W   320  frame-buffer width in pixels
//  SCREEN_H   240  frame-buffer height in pixels
//  FB_AW      17   frame-buffer address width (>= clog2(SCREEN_W*SCREEN_H))
//  SPR_AW     14   sprite-ROM address width
//  PIX_W      5    palette-index width, matching the ROM data_Out width
//  DIM_W      8    width of spr_w/spr_h (max sprite 255x255)
//  TRANSP     0    palette index treated as transparent (never written)
// PORTS
//  Clk        in   1        system clock
//  Reset      in   1        synchronous, active-high reset
//  start      in   1        job request; sampled only in IDLE
//  dst_x      in   11       signed screen X of sprite top-left (may be negative/off-screen)
//  dst_y      in   11       signed screen Y of sprite top-left
//  src_base   in   SPR_AW   ROM address of sprite pixel (0,0); row-major, stride = spr_w
//  spr_w      in   DIM_W    sprite width
//  spr_h      in   DIM_W    sprite height
//  busy       out  1        high from the cycle after start is accepted until done
//  done       out  1        one-cycle pulse at job completion
//  rom_addr   out  SPR_AW   sprite-ROM read address (registered)
//  rom_data   in   PIX_W    ROM output, valid one cycle after rom_addr
//  fb_addr    out  FB_AW    frame-buffer write address = y*SCREEN_W + x
//  fb_data    out  PIX_W    palette index to write
//  fb_we      out  1        write enable, one pixel per asserted cycle
// BEHAVIOUR
//  Reset: busy=0, done=0, fb_we=0, rom_addr=0, fb_addr=0, fb_data=0; FSM -> IDLE. Reset mid-job
//   aborts: fb_we=0 from the next cycle, no done pulse.
//  FSM: IDLE -(start)-> READ -(last addr issued)-> DRAIN -(2 cycles)-> DONE -> IDLE.
//  Job inputs latched when start is accepted at edge k; later input changes ignored. start ignored
//   while busy.
//  Timing, N = spr_w*spr_h: pixel i address on rom_addr in cycle k+1+i; rom_data in k+2+i; fb_we
//   slot for pixel i in k+3+i. done=1 and busy=0 in cycle k+N+3.
//  Scan order: row 0 cols 0..w-1, then row 1, ... Source address by running increment; no multiplier.
//  fb_addr from running row base (y*SCREEN_W via shift-add) plus x; no multiplier.
//  A pixel is written iff 0<=x<SCREEN_W, 0<=y<SCREEN_H and rom_data!=TRANSP. Otherwise the slot
//   keeps fb_we=0 and timing is unchanged, with no skipping ahead.
//  Clip check uses 12-bit signed arithmetic; x = dst_x+col cannot wrap into the visible range.
//  spr_w==0 or spr_h==0: no ROM reads and no writes; done pulses in cycle k+2.
//  Fully off-screen sprite: full N-cycle scan, zero writes, normal done timing.
// CONFIGURATION
//  SPRITE_BLIT_MIRROR_EN defined: extra input port hflip (1 bit), latched with the job.
//   When 1, each row reads columns w-1..0, so the ROM address decrements within the row.
//   Screen placement and timing are unchanged.
//  Undefined: no hflip port; columns always read ascending.
// STRUCTURE
//  sprite_pkg: SCREEN_W/SCREEN_H/PIX_W/TRANSP constants, typedef pix_idx_t [PIX_W-1:0],
//   typedef coord_t signed [10:0], enum blit_state_e {IDLE, READ, DRAIN, DONE}.
//  One sub-module: blit_addr_gen. It holds the row/col counters, source address, screen x/y and
//   last flag, and advances one pixel per enable. The top level holds the FSM, the 1-stage pipe
//   and the write qualification.
// TESTING
//  1. 4x2 sprite, dst=(10,20), src_base=100, all ROM data 3 -> 8 writes, fb_addr 6410..6413,
//     6730..6733; fb_we in k+3..k+10; done in k+11.
//  2. Same job, ROM data 0 at src 101 and 106 -> fb_we low in those two slots; done still at k+11.
//  3. 4x4 at dst=(-2,238) -> only x in {0,1}, y in {238,239} written: 4 writes, fb_addr 76160,
//     76161, 76480, 76481.
//  4. spr_w=0 -> no rom_addr change, no fb_we; done in k+2. start pulsed while busy -> ignored,
//     single done.
//  5. Reset asserted at k+5 of a 4x4 job -> fb_we=0, busy=0 from k+6; no done; new start then
//     behaves as test 1.
//  6. SPRITE_BLIT_MIRROR_EN, hflip=1, 4x1 at src_base=100 -> rom_addr 103,102,101,100; writes
//     land at ascending x.

Source files
------------

// File: rtl/sprite_blitter_pkg.sv
// Shared constants and types for the sprite blitter: screen geometry, palette index,
// signed coordinates and the blitter FSM state encoding.
package sprite_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int PIX_W    = 5;

  typedef logic [PIX_W-1:0]  pix_idx_t;
  typedef logic signed [10:0] coord_t;
  typedef logic signed [11:0] clip_t;
  typedef logic signed [20:0] rowb_t;

  localparam pix_idx_t TRANSP = {PIX_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } blit_state_e;

  // y*SCREEN_W as shift-add; SCREEN_W = 320 = 256 + 64
  function automatic rowb_t row_base_of(input coord_t y);
    rowb_t ys;
    ys = rowb_t'(y);
    return (ys <<< 8) + (ys <<< 6);
  endfunction

endpackage

// File: rtl/sprite_blitter_addr_gen.sv
// Pixel walker for one blit job: row/col counters, running source address, screen x/y and
// frame-buffer row base. Advances one pixel per adv; optional horizontal mirroring of the read order.
module blit_addr_gen
  import sprite_pkg::*;
#(
  parameter int SPR_AW = 14,
  parameter int DIM_W  = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              load,
  input  logic              adv,
  input  logic              flip,
  input  logic [SPR_AW-1:0] base,
  input  coord_t            dst_x,
  input  coord_t            dst_y,
  input  logic [DIM_W-1:0]  w,
  input  logic [DIM_W-1:0]  h,
  output logic [SPR_AW-1:0] src_addr,
  output clip_t             x,
  output clip_t             y,
  output rowb_t             row_base,
  output logic              last
);

  logic [DIM_W-1:0]  col_r, row_r, w_r, h_r;
  logic [SPR_AW-1:0] src_r, src_row_r;
  clip_t             x_r, y_r, dst_x_r;
  rowb_t             rb_r;
  logic              flip_r;

  // Load a new job or step to the next pixel in row-major order
  always_ff @(posedge Clk) begin
    if (Reset) begin
      col_r     <= {DIM_W{1'b0}};
      row_r     <= {DIM_W{1'b0}};
      w_r       <= {DIM_W{1'b0}};
      h_r       <= {DIM_W{1'b0}};
      src_r     <= {SPR_AW{1'b0}};
      src_row_r <= {SPR_AW{1'b0}};
      x_r       <= 12'sd0;
      y_r       <= 12'sd0;
      dst_x_r   <= 12'sd0;
      rb_r      <= 21'sd0;
      flip_r    <= 1'b0;
    end else if (load) begin
      col_r     <= {DIM_W{1'b0}};
      row_r     <= {DIM_W{1'b0}};
      w_r       <= w;
      h_r       <= h;
      flip_r    <= flip;
      src_row_r <= base;
      src_r     <= flip ? (base + SPR_AW'(w) - SPR_AW'(1)) : base;
      dst_x_r   <= clip_t'(dst_x);
      x_r       <= clip_t'(dst_x);
      y_r       <= clip_t'(dst_y);
      rb_r      <= row_base_of(dst_y);
    end else if (adv) begin
      if (col_r == w_r - DIM_W'(1)) begin
        col_r     <= {DIM_W{1'b0}};
        row_r     <= row_r + DIM_W'(1);
        x_r       <= dst_x_r;
        y_r       <= y_r + 12'sd1;
        rb_r      <= rb_r + rowb_t'(SCREEN_W);
        src_row_r <= src_row_r + SPR_AW'(w_r);
        // Mirrored rows start at their rightmost column: next row base + w - 1
        src_r     <= flip_r ? (src_row_r + (SPR_AW'(w_r) << 1) - SPR_AW'(1)) : (src_r + SPR_AW'(1));
      end else begin
        col_r <= col_r + DIM_W'(1);
        x_r   <= x_r + 12'sd1;
        src_r <= flip_r ? (src_r - SPR_AW'(1)) : (src_r + SPR_AW'(1));
      end
    end else begin
      col_r <= col_r;
    end
  end

  assign src_addr = src_r;
  assign x        = x_r;
  assign y        = y_r;
  assign row_base = rb_r;
  assign last     = (col_r == w_r - DIM_W'(1)) && (row_r == h_r - DIM_W'(1));

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: copies a sprite from a sync-read ROM into the frame buffer with transparency
// skip and screen-edge clipping. Define SPRITE_BLIT_MIRROR_EN to add the hflip input.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int FB_AW  = 17,
  parameter int SPR_AW = 14,
  parameter int DIM_W  = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  coord_t            dst_x,
  input  coord_t            dst_y,
  input  logic [SPR_AW-1:0] src_base,
  input  logic [DIM_W-1:0]  spr_w,
  input  logic [DIM_W-1:0]  spr_h,
`ifdef SPRITE_BLIT_MIRROR_EN
  input  logic              hflip,
`endif
  output logic              busy,
  output logic              done,
  output logic [SPR_AW-1:0] rom_addr,
  input  pix_idx_t          rom_data,
  output logic [FB_AW-1:0]  fb_addr,
  output pix_idx_t          fb_data,
  output logic              fb_we
);

  blit_state_e      state_r;
  logic             empty_r, drain_r;
  logic             flip_s, load_s, adv_s, last_s;
  clip_t            x_s, y_s;
  rowb_t            row_base_s;
  logic             s1_vld_r, s1_inb_r;
  logic [FB_AW-1:0] s1_addr_r;

`ifdef SPRITE_BLIT_MIRROR_EN
  assign flip_s = hflip;
`else
  assign flip_s = 1'b0;
`endif

  // Empty jobs never load the walker so rom_addr stays put
  assign load_s = (state_r == IDLE) && start && (spr_w != {DIM_W{1'b0}}) && (spr_h != {DIM_W{1'b0}});
  assign adv_s  = (state_r == READ) && !empty_r && !last_s;

  blit_addr_gen #(.SPR_AW(SPR_AW), .DIM_W(DIM_W)) u_addr_gen (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (load_s),
    .adv      (adv_s),
    .flip     (flip_s),
    .base     (src_base),
    .dst_x    (dst_x),
    .dst_y    (dst_y),
    .w        (spr_w),
    .h        (spr_h),
    .src_addr (rom_addr),
    .x        (x_s),
    .y        (y_s),
    .row_base (row_base_s),
    .last     (last_s)
  );

  // Job sequencing with registered busy/done
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      empty_r <= 1'b0;
      drain_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy    <= 1'b1;
            empty_r <= (spr_w == {DIM_W{1'b0}}) || (spr_h == {DIM_W{1'b0}});
            state_r <= READ;
          end else begin
            busy <= 1'b0;
          end
        end
        READ: begin
          if (empty_r) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= DONE;
          end else if (last_s) begin
            drain_r <= 1'b0;
            state_r <= DRAIN;
          end else begin
            state_r <= READ;
          end
        end
        DRAIN: begin
          // Two cycles let the last pixel pass the ROM and write stages
          if (drain_r) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= DONE;
          end else begin
            drain_r <= 1'b1;
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Coordinate stage aligned with ROM latency, then write qualification
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_vld_r  <= 1'b0;
      s1_inb_r  <= 1'b0;
      s1_addr_r <= {FB_AW{1'b0}};
      fb_we     <= 1'b0;
      fb_addr   <= {FB_AW{1'b0}};
      fb_data   <= {PIX_W{1'b0}};
    end else begin
      s1_vld_r  <= (state_r == READ) && !empty_r;
      s1_inb_r  <= (x_s >= 12'sd0) && (x_s < clip_t'(SCREEN_W)) &&
                   (y_s >= 12'sd0) && (y_s < clip_t'(SCREEN_H));
      s1_addr_r <= FB_AW'(row_base_s + rowb_t'(x_s));
      fb_we     <= s1_vld_r && s1_inb_r && (rom_data != TRANSP);
      if (s1_vld_r && s1_inb_r && (rom_data != TRANSP)) begin
        fb_addr <= s1_addr_r;
        fb_data <= rom_data;
      end else begin
        fb_addr <= fb_addr;
        fb_data <= fb_data;
      end
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: directed and random blit jobs checked every cycle
// against a per-pixel arithmetic model of the expected ROM reads and frame-buffer writes.
module tb_sprite_blitter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic signed [10:0] dst_x = 11'sd0, dst_y = 11'sd0;
  logic [13:0] src_base = 14'd0;
  logic [7:0]  spr_w = 8'd0, spr_h = 8'd0;
`ifdef SPRITE_BLIT_MIRROR_EN
  logic        hflip = 1'b0;
`endif
  logic        busy, done, fb_we;
  logic [13:0] rom_addr;
  logic [4:0]  rom_data = 5'd0;
  logic [16:0] fb_addr;
  logic [4:0]  fb_data;

  logic [4:0]  rom_mem [0:16383];

  int cyc = 0;
  int n_checks = 0, n_fail = 0;
  int j_k = 0, j_n = 0, j_w = 0, j_h = 0, j_dx = 0, j_dy = 0, j_base = 0, j_flip = 0;
  bit j_act = 1'b0;
  int rom_hold = 0, wr_cnt = 0, done_t = -1;

  sprite_blitter dut (
    .Clk(Clk), .Reset(Reset), .start(start), .dst_x(dst_x), .dst_y(dst_y),
    .src_base(src_base), .spr_w(spr_w), .spr_h(spr_h),
`ifdef SPRITE_BLIT_MIRROR_EN
    .hflip(hflip),
`endif
    .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  always @(posedge Clk) rom_data <= rom_mem[rom_addr];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Model: pixel i of the current job in scan order
  function automatic int pix_src(input int i);
    int row, col;
    row = i / j_w;
    col = i % j_w;
    return (j_base + row * j_w + (j_flip != 0 ? (j_w - 1 - col) : col)) & 16383;
  endfunction
  function automatic int pix_x(input int i);
    return j_dx + i % j_w;
  endfunction
  function automatic int pix_y(input int i);
    return j_dy + i / j_w;
  endfunction
  function automatic int model_fb(input int i);
    return pix_y(i) * 320 + pix_x(i);
  endfunction

  // Per-cycle comparison of every output against the model
  always @(negedge Clk) begin
    int t, i, x, y, d, er, efa, efd;
    bit eb, ed, ew;
    if (cyc >= 2) begin
      eb = 0; ed = 0; ew = 0; er = rom_hold; efa = 0; efd = 0;
      if (j_act) begin
        t = cyc - j_k;
        if (j_n > 0) begin
          eb = (t >= 1 && t <= j_n + 2);
          ed = (t == j_n + 3);
          if (t >= 1 && t <= j_n) er = pix_src(t - 1);
          else if (t > j_n) er = pix_src(j_n - 1);
          if (t >= 3 && t <= j_n + 2) begin
            i = t - 3;
            x = pix_x(i);
            y = pix_y(i);
            d = int'(rom_mem[pix_src(i)]);
            ew = (x >= 0 && x < 320 && y >= 0 && y < 240 && d != 0);
            efa = y * 320 + x;
            efd = d;
          end
        end else begin
          eb = (t == 1);
          ed = (t == 2);
        end
        if (done) done_t = t;
      end
      check("busy", busy, eb);
      check("done", done, ed);
      check("fb_we", fb_we, ew);
      check("rom_addr", rom_addr, er);
      if (ew) begin
        check("fb_addr", fb_addr, efa);
        check("fb_data", fb_data, efd);
      end
      if (fb_we) wr_cnt++;
    end
  end

  task automatic run_job(input int w, input int h, input int dx, input int dy, input int base,
                         input int flip, input int abort_t, input int exp_wr, input int exp_dt);
    int n, t;
    n = w * h;
    @(negedge Clk); #2;
    dst_x = 11'(dx); dst_y = 11'(dy); src_base = 14'(base);
    spr_w = 8'(w); spr_h = 8'(h);
`ifdef SPRITE_BLIT_MIRROR_EN
    hflip = flip[0];
`endif
    start = 1'b1;
    j_k = cyc; j_n = n; j_w = w; j_h = h; j_dx = dx; j_dy = dy; j_base = base;
    j_flip = flip; j_act = 1'b1; wr_cnt = 0; done_t = -1;
    forever begin
      @(negedge Clk); #2;
      t = cyc - j_k;
      start = (t == 3 && n > 0);
      if (t == 1) begin
        dst_x = 11'($urandom); dst_y = 11'($urandom); src_base = 14'($urandom);
        spr_w = 8'($urandom); spr_h = 8'($urandom);
`ifdef SPRITE_BLIT_MIRROR_EN
        hflip = 1'($urandom);
`endif
      end
      if (abort_t > 0 && t == abort_t) begin
        start = 1'b0; Reset = 1'b1; j_act = 1'b0; rom_hold = 0;
        @(negedge Clk); #2;
        Reset = 1'b0;
        break;
      end
      if (t == (n > 0 ? n + 4 : 3)) begin
        if (n > 0) rom_hold = pix_src(n - 1);
        break;
      end
    end
    if (exp_wr >= 0) check("write_count", wr_cnt, exp_wr);
    if (exp_dt != -2) check("done_cycle", done_t, exp_dt);
  endtask

  initial begin
    int fl, dx, dy;
    for (int a = 0; a < 16384; a++)
      rom_mem[a] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    for (int a = 100; a < 108; a++) rom_mem[a] = 5'd3;
    repeat (4) @(negedge Clk);
    #2 Reset = 1'b0;
    repeat (2) @(negedge Clk);

    // 4x2 solid sprite
    run_job(4, 2, 10, 20, 100, 0, 0, 8, 11);
    check("pin_fb0", model_fb(0), 6410);
    check("pin_fb3", model_fb(3), 6413);
    check("pin_fb4", model_fb(4), 6730);
    check("pin_fb7", model_fb(7), 6733);

    // Transparent pixels at src 101 and 106
    rom_mem[101] = 5'd0; rom_mem[106] = 5'd0;
    run_job(4, 2, 10, 20, 100, 0, 0, 6, 11);
    rom_mem[101] = 5'd3; rom_mem[106] = 5'd3;

    // Clipped at left and bottom edges
    run_job(4, 4, -2, 238, 100, 0, 0, 4, 19);
    check("pin_clip_a", model_fb(2), 76160);
    check("pin_clip_b", model_fb(7), 76481);

    // Empty sprites
    run_job(0, 5, 10, 10, 500, 0, 0, 0, 2);
    run_job(3, 0, 10, 10, 600, 0, 0, 0, 2);

    // Fully off-screen: full scan, no writes
    run_job(3, 3, -300, 10, 700, 0, 0, 0, 12);

    // Reset mid-job, then the reference job again
    run_job(4, 4, 10, 20, 100, 0, 5, -1, -1);
    run_job(4, 2, 10, 20, 100, 0, 0, 8, 11);

`ifdef SPRITE_BLIT_MIRROR_EN
    rom_mem[100] = 5'd1; rom_mem[101] = 5'd2; rom_mem[102] = 5'd3; rom_mem[103] = 5'd4;
    run_job(4, 1, 10, 20, 100, 1, 0, 4, 7);
    check("pin_mirror0", pix_src(0), 103);
    check("pin_mirror3", pix_src(3), 100);
    check("mirror_last_data", fb_data, 1);
`endif

    // Random jobs
    for (int r = 0; r < 24; r++) begin
      dx = $urandom_range(0, 360) - 30;
      dy = $urandom_range(0, 280) - 30;
      if (r % 6 == 5) dx = -600;
`ifdef SPRITE_BLIT_MIRROR_EN
      fl = int'($urandom_range(0, 1));
`else
      fl = 0;
`endif
      run_job($urandom_range(0, 10), $urandom_range(0, 10), dx, dy,
              $urandom_range(0, 16000), fl, 0, -1, -2);
    end

    repeat (3) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
